// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the MEM-stage load/store unit.
package lsu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Size encoding 3 falls through to word everywhere.
    function automatic logic [STRB_W-1:0] size_wstrb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extend_load(input logic [1:0] size, input logic [1:0] off,
                                                       input logic zext, input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (size)
            SZ_B:    return zext ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    return zext ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: store strobes/replication and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_offset,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_offset,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [STRB_W-1:0] st_wstrb_c,
    output logic [DATA_W-1:0] st_lanes_c,
    output logic [DATA_W-1:0] ld_data_c
);

    // Replicating the low bytes lets memory pick any lane via the strobes.
    always_comb begin
        st_wstrb_c = size_wstrb(st_size, st_offset);
        case (st_size)
            SZ_B:    st_lanes_c = {4{st_wdata[7:0]}};
            SZ_H:    st_lanes_c = {2{st_wdata[15:0]}};
            default: st_lanes_c = st_wdata;
        endcase
        ld_data_c = extend_load(ld_size, ld_offset, ld_unsigned, ld_rdata);
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one valid/ready memory transaction per EXE/MEM request,
// stalling the pipeline until the response (or a timeout) completes the access.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [REG_W-1:0]  req_rd,
    output logic              waiting,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [STRB_W-1:0] mem_req_wstrb,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              mem_resp_err,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              lsu_exc
);

    lsu_state_e           state;
    logic [TIMEOUT_W-1:0] cnt;
    logic [1:0]           size_q;
    logic [1:0]           off_q;
    logic                 unsigned_q;
    logic                 is_write_c;
    logic [STRB_W-1:0]    st_wstrb_c;
    logic [DATA_W-1:0]    st_lanes_c;
    logic [DATA_W-1:0]    ld_data_c;

    assign is_write_c = req_write && !req_read;

    // Stall must rise in the accept cycle itself so EXE/MEM holds the request.
    assign waiting = (state == S_IDLE && (req_read || req_write)) ||
                     state == S_REQ || state == S_RESP;

    lsu_align u_align (
        .st_size     (req_size),
        .st_offset   (req_addr[1:0]),
        .st_wdata    (req_wdata),
        .ld_size     (size_q),
        .ld_offset   (off_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (mem_resp_rdata),
        .st_wstrb_c  (st_wstrb_c),
        .st_lanes_c  (st_lanes_c),
        .ld_data_c   (ld_data_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            size_q        <= 2'b00;
            off_q         <= 2'b00;
            unsigned_q    <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wstrb <= '0;
            mem_req_wdata <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            lsu_exc       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            lsu_exc  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_read || req_write) begin
                        mem_req_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        mem_req_write <= is_write_c;
                        mem_req_wstrb <= is_write_c ? st_wstrb_c : 4'h0;
                        mem_req_wdata <= st_lanes_c;
                        size_q        <= req_size;
                        off_q         <= req_addr[1:0];
                        unsigned_q    <= req_unsigned;
                        wb_rd         <= req_rd;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state   <= S_DONE;
                            lsu_exc <= 1'b1;
                        end else begin
                            state         <= S_REQ;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    // A response arriving in the timeout cycle still completes normally.
                    if (mem_resp_valid) begin
                        state    <= S_DONE;
                        lsu_exc  <= mem_resp_err;
                        wb_valid <= !mem_req_write && !mem_resp_err;
                        if (!mem_req_write) begin
                            wb_data <= ld_data_c;
                        end
                    end else if (cnt == TIMEOUT_W'(TIMEOUT)) begin
                        state   <= S_DONE;
                        lsu_exc <= 1'b1;
                    end else begin
                        cnt <= cnt + TIMEOUT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
